// File: rtl/tub_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the tube scheduler.
// Geometry defaults, initial tube table, LFSR seed and per-lane byte pick.
package tub_scheduler_pkg;

  localparam int H_WRAP = 850;
  localparam int TUB_W  = 60;
  localparam int GAP    = 120;
  localparam int V_MAX  = 480;

  localparam logic [3:0][9:0] INIT_H = {
    10'd836, 10'd624, 10'd412, 10'd200
  };

  localparam logic [9:0]  GAP_TOP_INIT = 10'd180;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Byte 0 of the LFSR rotated left by 4*lane, so lanes that
  // wrap together draw different random bytes.
  function automatic logic [7:0] lane_rnd(
    input logic [15:0] l,
    input int          lane
  );
    return 8'({l, l} >> (16 - 4 * lane));
  endfunction

endpackage

// File: rtl/tub_lane.sv
// One tube: horizontal position, gap top and lower-tube geometry.
// Ports: restore/move controls, step, rnd byte, pass_x; h/geometry/pass out.
module tub_lane #(
  parameter int         H_WRAP = tub_scheduler_pkg::H_WRAP,
  parameter int         GAP    = tub_scheduler_pkg::GAP,
  parameter int         V_MAX  = tub_scheduler_pkg::V_MAX,
  parameter logic [9:0] INIT_H = 10'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restore,
  input  logic       move,
  input  logic [2:0] step,
  input  logic [7:0] rnd,
  input  logic [9:0] pass_x,
  output logic [9:0] h,
  output logic [9:0] gap_top,
  output logic [9:0] low_v,
  output logic [9:0] low_ht,
  output logic       pass
);
  import tub_scheduler_pkg::*;

  localparam logic [9:0] GAP10  = 10'(GAP);
  localparam logic [9:0] SPAN10 = 10'(V_MAX - GAP);
  localparam logic [9:0] WRAP10 = 10'(H_WRAP);

  logic       wrap;
  logic [9:0] step10;
  logic [9:0] h_dec;
  logic [9:0] h_wrp;
  logic [9:0] gap_new;

  assign step10  = {7'd0, step};
  assign wrap    = h < step10;
  assign h_dec   = h - step10;
  // h < step here, so h + H_WRAP stays inside 10 bits
  assign h_wrp   = h + WRAP10 - step10;
  assign gap_new = 10'd64 + {2'd0, rnd};
  assign pass    = !wrap && (h >= pass_x) && (h_dec < pass_x);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h       <= INIT_H;
      gap_top <= GAP_TOP_INIT;
      low_v   <= GAP_TOP_INIT + GAP10;
      low_ht  <= SPAN10 - GAP_TOP_INIT;
    end else if (restore) begin
      h       <= INIT_H;
      gap_top <= GAP_TOP_INIT;
      low_v   <= GAP_TOP_INIT + GAP10;
      low_ht  <= SPAN10 - GAP_TOP_INIT;
    end else if (move) begin
      if (wrap) begin
        h       <= h_wrp;
        gap_top <= gap_new;
        low_v   <= gap_new + GAP10;
        low_ht  <= SPAN10 - gap_new;
      end else begin
        h <= h_dec;
      end
    end
  end

endmodule

// File: rtl/tub_scheduler.sv
// Scrolling tube scheduler: game FSM, LFSR, hit latch, score, four lanes.
// Ports: clk/rst, frame_tick, start, hit, speed, pass_x; tube geometry, score, state.
module tub_scheduler #(
  parameter int H_WRAP = tub_scheduler_pkg::H_WRAP,
  parameter int TUB_W  = tub_scheduler_pkg::TUB_W,
  parameter int GAP    = tub_scheduler_pkg::GAP,
  parameter int V_MAX  = tub_scheduler_pkg::V_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  input  logic [2:0]  speed,
  input  logic [9:0]  pass_x,
  output logic [19:0] tub_loc_0,
  output logic [19:0] tub_loc_1,
  output logic [19:0] tub_loc_2,
  output logic [19:0] tub_loc_3,
  output logic [19:0] tub_loc_0_U,
  output logic [19:0] tub_loc_1_U,
  output logic [19:0] tub_loc_2_U,
  output logic [19:0] tub_loc_3_U,
  output logic [19:0] tub_size_0,
  output logic [19:0] tub_size_1,
  output logic [19:0] tub_size_2,
  output logic [19:0] tub_size_3,
  output logic [19:0] tub_size_0_U,
  output logic [19:0] tub_size_1_U,
  output logic [19:0] tub_size_2_U,
  output logic [19:0] tub_size_3_U,
  output logic [7:0]  score,
  output logic [1:0]  state
);
  import tub_scheduler_pkg::*;

  localparam logic [9:0] W10 = 10'(TUB_W);

  state_t      state_q;
  state_t      state_d;
  logic        hit_q;
  logic        hit_any;
  logic        move;
  logic        restore;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [2:0]  step;
  logic [2:0]  cnt;
  logic [8:0]  sum;
  logic [3:0]  pass;
  logic [9:0]  h       [4];
  logic [9:0]  gap_top [4];
  logic [9:0]  low_v   [4];
  logic [9:0]  low_ht  [4];

  assign hit_any = hit_q | hit;
  assign step    = (speed == 3'd0) ? 3'd1 : speed;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    move    = 1'b0;
    restore = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (frame_tick) begin
          if (hit_any) state_d = ST_OVER;
          else         move    = 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_IDLE;
          restore = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Latch only gathers hits between ticks; a tick consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hit_q <= 1'b0;
    else if (state_q == ST_PLAY && !frame_tick)
      hit_q <= hit_any;
    else
      hit_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < 4; i++)
      cnt = cnt + {2'd0, pass[i]};
  end

  assign sum = {1'b0, score} + {6'd0, cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         score <= 8'd0;
    else if (restore) score <= 8'd0;
    else if (move)    score <= sum[8] ? 8'hFF : sum[7:0];
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    tub_lane #(
      .H_WRAP (H_WRAP),
      .GAP    (GAP),
      .V_MAX  (V_MAX),
      .INIT_H (INIT_H[i])
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .restore (restore),
      .move    (move),
      .step    (step),
      .rnd     (lane_rnd(lfsr_q, i)),
      .pass_x  (pass_x),
      .h       (h[i]),
      .gap_top (gap_top[i]),
      .low_v   (low_v[i]),
      .low_ht  (low_ht[i]),
      .pass    (pass[i])
    );
  end

  assign state = state_q;

  assign tub_loc_0 = {h[0], low_v[0]};
  assign tub_loc_1 = {h[1], low_v[1]};
  assign tub_loc_2 = {h[2], low_v[2]};
  assign tub_loc_3 = {h[3], low_v[3]};

  assign tub_loc_0_U = {h[0], 10'd0};
  assign tub_loc_1_U = {h[1], 10'd0};
  assign tub_loc_2_U = {h[2], 10'd0};
  assign tub_loc_3_U = {h[3], 10'd0};

  assign tub_size_0 = {W10, low_ht[0]};
  assign tub_size_1 = {W10, low_ht[1]};
  assign tub_size_2 = {W10, low_ht[2]};
  assign tub_size_3 = {W10, low_ht[3]};

  assign tub_size_0_U = {W10, gap_top[0]};
  assign tub_size_1_U = {W10, gap_top[1]};
  assign tub_size_2_U = {W10, gap_top[2]};
  assign tub_size_3_U = {W10, gap_top[3]};

endmodule
